// File: rtl/bin2ascii_conv.sv
// Handshaked binary-to-ASCII decimal converter: iterative double-dabble, one bit per enabled cycle,
// right-justified output with leading-zero suppression and optional '-' sign.
module bin2ascii_conv #(
    parameter int BITS_IN   = 32,
    parameter int DIGITS    = 10,
    parameter int CNT_W     = 6,
    parameter int SIGNED_EN = 0
) (
    input  logic                    clk_i,
    input  logic                    rst_i,
    input  logic                    ce_i,
    input  logic                    in_valid_i,
    output logic                    in_ready_o,
    input  logic [BITS_IN-1:0]      dat_i,
    output logic                    out_valid_o,
    input  logic                    out_ready_i,
    output logic [8*(DIGITS+1)-1:0] ascii_o,
    output logic [CNT_W-1:0]        len_o,
    output logic                    neg_o
);

    localparam int BCD_W = 4 * DIGITS;
    localparam int OUT_W = 8 * (DIGITS + 1);

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_CONV = 2'd1;
    localparam logic [1:0] S_DONE = 2'd2;

    // True when 10^DIGITS >= 2^BITS_IN; wide enough for any legal BITS_IN.
    function automatic bit digits_ok();
        logic [255:0] p;
        p = 256'd1;
        for (int i = 0; i < DIGITS && i < 70; i++) p = p * 256'd10;
        return (DIGITS >= 70) || (p >= (256'd1 << BITS_IN));
    endfunction

    generate
        if (BITS_IN < 4 || BITS_IN > 64) begin : g_bad_bits
            $error("bin2ascii_conv: BITS_IN out of range 4..64");
        end
        if (!digits_ok()) begin : g_bad_digits
            $error("bin2ascii_conv: DIGITS too small for BITS_IN");
        end
        if ((1 << CNT_W) <= BITS_IN) begin : g_bad_cnt
            $error("bin2ascii_conv: CNT_W too small for BITS_IN");
        end
    endgenerate

    function automatic logic [BCD_W-1:0] bcd_asl(input logic [BCD_W-1:0] bcd, input logic bit_in);
        logic [BCD_W-1:0] adj;
        adj = bcd;
        for (int k = 0; k < DIGITS; k++) begin
            if (adj[4*k +: 4] > 4'd4) adj[4*k +: 4] = adj[4*k +: 4] + 4'd3;
        end
        return {adj[BCD_W-2:0], bit_in};
    endfunction

    logic [1:0]         r_state;
    logic [BITS_IN-1:0] r_shift;
    logic [BCD_W-1:0]   r_bcd;
    logic [CNT_W-1:0]   r_cnt;
    logic               r_neg;
    logic [OUT_W-1:0]   r_ascii;
    logic [CNT_W-1:0]   r_len;
    logic               r_neg_out;

    logic [BCD_W-1:0]   w_bcd_nxt;
    logic               w_last;
    logic               w_in_neg;
    logic [OUT_W-1:0]   w_ascii;
    logic [CNT_W-1:0]   w_len;
    logic               w_bad;

    assign w_bcd_nxt = bcd_asl(r_bcd, r_shift[BITS_IN-1]);
    assign w_last    = (r_cnt == CNT_W'(BITS_IN - 1));
    assign w_in_neg  = (SIGNED_EN != 0) && dat_i[BITS_IN-1];

    // Format the final BCD value so it can be registered on the last shift edge.
    always_comb begin
        int nz;
        nz      = 0;
        w_ascii = '0;
        w_bad   = 1'b0;
        for (int k = 0; k < DIGITS; k++) begin
            if (w_bcd_nxt[4*k +: 4] != 4'd0) nz = k;
        end
        for (int k = 0; k < DIGITS; k++) begin
            if (w_bcd_nxt[4*k +: 4] > 4'd9) w_bad = 1'b1;
            if (k <= nz) begin
                w_ascii[8*k +: 8] = (w_bcd_nxt[4*k +: 4] > 4'd9) ? 8'h3F : {4'h3, w_bcd_nxt[4*k +: 4]};
            end
        end
        if (r_neg) w_ascii[8*(nz+1) +: 8] = 8'h2D;
        w_len = CNT_W'(nz + 1 + (r_neg ? 1 : 0));
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            r_state   <= S_IDLE;
            r_shift   <= '0;
            r_bcd     <= '0;
            r_cnt     <= '0;
            r_neg     <= 1'b0;
            r_ascii   <= '0;
            r_len     <= '0;
            r_neg_out <= 1'b0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (in_valid_i) begin
                        // Negation in BITS_IN bits keeps the most-negative value correct as unsigned.
                        r_shift <= w_in_neg ? (~dat_i + 1'b1) : dat_i;
                        r_neg   <= w_in_neg;
                        r_bcd   <= '0;
                        r_cnt   <= '0;
                        r_state <= S_CONV;
                    end
                end
                S_CONV: begin
                    if (ce_i) begin
                        r_bcd   <= w_bcd_nxt;
                        r_shift <= r_shift << 1;
                        r_cnt   <= r_cnt + 1'b1;
                        if (w_last) begin
                            r_ascii   <= w_ascii;
                            r_len     <= w_len;
                            r_neg_out <= r_neg;
                            r_state   <= S_DONE;
                        end
                    end
                end
                S_DONE: begin
                    if (out_ready_i) r_state <= S_IDLE;
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

    always_ff @(posedge clk_i) begin
        if (!rst_i && r_state == S_CONV && ce_i && w_last) begin
            assert (!w_bad) else $error("bin2ascii_conv: BCD digit above 9");
        end
    end

    assign in_ready_o  = (r_state == S_IDLE);
    assign out_valid_o = (r_state == S_DONE);
    assign ascii_o     = r_ascii;
    assign len_o       = r_len;
    assign neg_o       = r_neg_out;

endmodule

// File: tb/tb_bin2ascii_conv.sv
// Bench for bin2ascii_conv: unsigned and signed instances share stimulus, each checked against its own expectation.
module tb_bin2ascii_conv;

    localparam int BITS_IN = 32;
    localparam int DIGITS  = 10;
    localparam int CNT_W   = 6;
    localparam int OUT_W   = 88;

    logic             clk = 1'b0;
    logic             rst, ce, in_valid, out_ready;
    logic [31:0]      dat;
    logic             in_ready_u, out_valid_u, neg_u;
    logic             in_ready_s, out_valid_s, neg_s;
    logic [OUT_W-1:0] ascii_u, ascii_s;
    logic [CNT_W-1:0] len_u, len_s;

    always #5 clk = ~clk;

    bin2ascii_conv #(.BITS_IN(BITS_IN), .DIGITS(DIGITS), .CNT_W(CNT_W), .SIGNED_EN(0)) u_dut_u (
        .clk_i(clk), .rst_i(rst), .ce_i(ce), .in_valid_i(in_valid), .in_ready_o(in_ready_u),
        .dat_i(dat), .out_valid_o(out_valid_u), .out_ready_i(out_ready),
        .ascii_o(ascii_u), .len_o(len_u), .neg_o(neg_u)
    );

    bin2ascii_conv #(.BITS_IN(BITS_IN), .DIGITS(DIGITS), .CNT_W(CNT_W), .SIGNED_EN(1)) u_dut_s (
        .clk_i(clk), .rst_i(rst), .ce_i(ce), .in_valid_i(in_valid), .in_ready_o(in_ready_s),
        .dat_i(dat), .out_valid_o(out_valid_s), .out_ready_i(out_ready),
        .ascii_o(ascii_s), .len_o(len_s), .neg_o(neg_s)
    );

    typedef struct {
        logic [31:0]      dat;
        logic [OUT_W-1:0] asc_u;
        logic [CNT_W-1:0] len_u;
        logic [OUT_W-1:0] asc_s;
        logic [CNT_W-1:0] len_s;
        logic             neg_s;
    } vec_t;

    vec_t sb_q[$];
    vec_t tbl[10];
    vec_t mon_e;
    int   n_cmp = 0;
    int   n_bad = 0;

    task automatic check(input string name, input logic [OUT_W-1:0] act, input logic [OUT_W-1:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    // Decimal reference by repeated division.
    function automatic void model(input logic [31:0] d, input bit sgn,
                                  output logic [OUT_W-1:0] asc, output logic [CNT_W-1:0] len);
        logic [63:0] m;
        bit          neg;
        int          n;
        neg = sgn && d[31];
        m   = neg ? (64'h1_0000_0000 - {32'h0, d}) : {32'h0, d};
        asc = '0;
        n   = 0;
        do begin
            asc[8*n +: 8] = 8'h30 + 8'(m % 64'd10);
            m = m / 64'd10;
            n++;
        end while (m != 64'd0);
        if (neg) begin
            asc[8*n +: 8] = 8'h2D;
            n++;
        end
        len = CNT_W'(n);
    endfunction

    function automatic vec_t mk_model(input logic [31:0] d);
        vec_t e;
        e.dat = d;
        model(d, 1'b0, e.asc_u, e.len_u);
        model(d, 1'b1, e.asc_s, e.len_s);
        e.neg_s = d[31];
        return e;
    endfunction

    always @(negedge clk) begin
        if (!rst && out_valid_u && out_ready) begin
            if (sb_q.size() == 0) begin
                n_cmp++;
                n_bad++;
                $display("FAIL unexpected_output: got out_valid=1, expected no result pending");
            end else begin
                mon_e = sb_q.pop_front();
                check("ascii_u", ascii_u, mon_e.asc_u);
                check("len_u", OUT_W'(len_u), OUT_W'(mon_e.len_u));
                check("neg_u", OUT_W'(neg_u), OUT_W'(1'b0));
                check("valid_s", OUT_W'(out_valid_s), OUT_W'(1'b1));
                check("ascii_s", ascii_s, mon_e.asc_s);
                check("len_s", OUT_W'(len_s), OUT_W'(mon_e.len_s));
                check("neg_s", OUT_W'(neg_s), OUT_W'(mon_e.neg_s));
            end
        end
    end

    task automatic send(input vec_t e);
        int t;
        t = 0;
        @(posedge clk); #2;
        while (!in_ready_u && t < 300) begin
            @(posedge clk); #2;
            t++;
        end
        if (!in_ready_u) begin
            n_cmp++;
            n_bad++;
            $display("FAIL send_timeout: in_ready_o=0 after %0d cycles, expected 1", t);
        end else begin
            in_valid = 1'b1;
            dat      = e.dat;
            sb_q.push_back(e);
            @(posedge clk); #2;
            in_valid = 1'b0;
        end
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time exhausted, expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        int   n;
        bit   rdy_seen;
        vec_t e;

        rst = 1'b1; ce = 1'b1; in_valid = 1'b0; out_ready = 1'b1; dat = '0;

        tbl[0] = '{32'h0000_0000, 88'("0"),          6'd1,  88'("0"),           6'd1,  1'b0};
        tbl[1] = '{32'hFFFF_FFFF, 88'("4294967295"), 6'd10, 88'("-1"),          6'd2,  1'b1};
        tbl[2] = '{32'h8000_0000, 88'("2147483648"), 6'd10, 88'("-2147483648"), 6'd11, 1'b1};
        tbl[3] = '{32'd12345,     88'("12345"),      6'd5,  88'("12345"),       6'd5,  1'b0};
        tbl[4] = '{32'd987,       88'("987"),        6'd3,  88'("987"),         6'd3,  1'b0};
        tbl[5] = '{32'h7FFF_FFFF, 88'("2147483647"), 6'd10, 88'("2147483647"),  6'd10, 1'b0};
        tbl[6] = '{32'd10,        88'("10"),         6'd2,  88'("10"),          6'd2,  1'b0};
        tbl[7] = '{32'd1000000000, 88'("1000000000"), 6'd10, 88'("1000000000"), 6'd10, 1'b0};
        tbl[8] = '{32'hFFFF_FFF6, 88'("4294967286"), 6'd10, 88'("-10"),         6'd3,  1'b1};
        tbl[9] = '{32'd9,         88'("9"),          6'd1,  88'("9"),           6'd1,  1'b0};

        #23 rst = 1'b0;
        #1;
        check("rst_in_ready", OUT_W'(in_ready_u), OUT_W'(1'b1));
        check("rst_out_valid", OUT_W'(out_valid_u), OUT_W'(1'b0));
        check("rst_ascii", ascii_u, '0);
        check("rst_len", OUT_W'(len_u), '0);
        check("rst_neg_s", OUT_W'(neg_s), '0);

        // Latency with ce held high, value 0.
        send(tbl[0]);
        n = 0; rdy_seen = 0;
        while (!out_valid_u && n < 200) begin
            @(posedge clk); #2;
            n++;
            if (!out_valid_u && in_ready_u) rdy_seen = 1;
        end
        check("latency_ce1", OUT_W'(n), OUT_W'(32));
        check("in_ready_conv", OUT_W'(rdy_seen), OUT_W'(1'b0));

        for (int i = 0; i < 10; i++) send(tbl[i]);
        for (int i = 0; i < 8; i++) send(mk_model($urandom));

        // ce toggling: every other edge is enabled, so 32 shifts span 64 edges.
        send(tbl[3]);
        n = 0; rdy_seen = 0;
        while (!out_valid_u && n < 300) begin
            ce = (n % 2 == 1);
            @(posedge clk); #2;
            n++;
            if (!out_valid_u && in_ready_u) rdy_seen = 1;
        end
        ce = 1'b1;
        check("latency_ce_toggle", OUT_W'(n), OUT_W'(64));
        check("in_ready_conv_toggle", OUT_W'(rdy_seen), OUT_W'(1'b0));

        // Back-pressure: result held, new inputs ignored.
        @(posedge clk); #2;
        out_ready = 1'b0;
        e = tbl[5];
        send(e);
        n = 0;
        while (!out_valid_u && n < 200) begin
            @(posedge clk); #2;
            n++;
        end
        for (int c = 0; c < 20; c++) begin
            in_valid = (c % 2 == 0);
            dat      = $urandom;
            @(posedge clk); #2;
            check("bp_in_ready", OUT_W'(in_ready_u), OUT_W'(1'b0));
            check("bp_out_valid", OUT_W'(out_valid_u), OUT_W'(1'b1));
            check("bp_ascii_u", ascii_u, e.asc_u);
            check("bp_ascii_s", ascii_s, e.asc_s);
        end
        in_valid  = 1'b1;
        dat       = 32'd55555;
        out_ready = 1'b1;
        @(posedge clk); #2;
        in_valid = 1'b0;
        check("release_in_ready", OUT_W'(in_ready_u), OUT_W'(1'b1));
        check("release_out_valid", OUT_W'(out_valid_u), OUT_W'(1'b0));
        check("release_hold_ascii", ascii_u, e.asc_u);
        send(tbl[6]);

        // Asynchronous reset mid-conversion.
        send(tbl[3]);
        repeat (10) @(posedge clk);
        #3 rst = 1'b1;
        #1;
        check("arst_out_valid", OUT_W'(out_valid_u), OUT_W'(1'b0));
        check("arst_in_ready", OUT_W'(in_ready_u), OUT_W'(1'b1));
        check("arst_in_ready_s", OUT_W'(in_ready_s), OUT_W'(1'b1));
        check("arst_ascii", ascii_u, '0);
        void'(sb_q.pop_back());
        #3 rst = 1'b0;
        send(tbl[4]);

        n = 0;
        while (sb_q.size() != 0 && n < 300) begin
            @(posedge clk); #2;
            n++;
        end
        check("drain_pending", OUT_W'(sb_q.size()), '0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
